disp_arbiter: RTL and testbench
===============================

# disp_arbiter

Arbiter that shares the board's two-digit seven-segment display between the output register and three transient requesters, such as debug views of PC, MAR or the accumulator. It sits between the datapath and the seven-segment driver, and its `disp` output feeds the driver's `OBUS` input. By default it shows `OBUS` live. A transient request takes the display for a fixed hold time with a frozen snapshot, and competing requests are served round-robin.

## Interface
Parameters:
- `HOLD_CYC`, default 50_000_000: cycles a granted source is shown (1 s at 50 MHz). Legal range is 1 to 2^26-1.
- `CW`, default 26: hold counter width.

Ports:
- `clk`, in, 1: system clock.
- `CLR`, in, 1: reset, asynchronous, active-high.
- `OBUS`, in, 8: output register value (source 0), shown live.
- `d1`, `d2`, `d3`, in, 8 each: data for transient sources 1–3.
- `req`, in, 3: `req[i-1]` requests display for source i. Only its rising edge is significant.
- `lock`, in, 1: freeze the current view.
- `disp`, out, 8: byte to the seven-segment driver.
- `gnt`, out, 2: index of the source currently shown (0–3).
- `ack`, out, 3: one-cycle pulse on `ack[i-1]` when source i is granted.
- `busy`, out, 1: high while a transient source is shown.

## Operation
- Edge detect:
  - `req_q` is a registered copy of `req`.
  - `rise = req & ~req_q`.
  - A level held high produces one request only.
- Pending:
  - `pending_next = (pending & ~grant_onehot) | rise`.
  - A rise for a source in the same cycle it is granted re-queues it.
- Round-robin:
  - Pointer `ptr` holds the last granted source (1–3).
  - The search order is `ptr+1`, `ptr+2`, `ptr+3`, wrapping within 1..3.
  - The first pending source in that order wins, and `ptr` updates to the winner.
- State machine, two states:
  - IDLE: `gnt = 0`, `disp` tracks `OBUS` with 1-cycle register delay, `busy = 0`.
    - If `pending != 0` and `lock = 0`: grant the winner and go to SHOW.
    - `lock = 1` in IDLE blocks grants; pending requests are retained.
  - SHOW: `disp` holds the snapshot of `d[gnt]` taken at grant, `busy = 1`.
    - `cnt` increments each cycle while `lock = 0` and is frozen while `lock = 1`.
    - When `cnt == HOLD_CYC-1` and `lock = 0`, with `pending != 0`: grant the next winner back-to-back, stay in SHOW, reset `cnt` to 0.
    - Same condition with `pending == 0`: go to IDLE.
- Grant cycle actions, all registered on the same edge:
  - `gnt` = winner.
  - `disp` = `d[winner]`.
  - `ack[winner-1]` = 1 for exactly one cycle.
  - `cnt` = 0.
  - The winner's pending bit is cleared.
- Changes on `d1`–`d3` after grant do not affect `disp`.

## Timing
- Reset values:
  - `disp` = 0x00, `gnt` = 0, `ack` = 0, `busy` = 0.
  - `pending` = 0, `req_q` = 0, `cnt` = 0.
  - `ptr` = 3, so the first search starts at source 1.
  - State = IDLE.
- Assertion of `CLR` in any state forces these values immediately, without waiting for a clock edge. In-flight pending requests are discarded.
- Request latency:
  - `req` rises, sampled at edge N: pending is set after edge N.
  - Grant occurs after edge N+1, where `gnt`, `disp`, `ack` and `busy` update, given IDLE and `lock = 0`.
- Hold duration: a SHOW grant lasts exactly `HOLD_CYC` cycles plus the number of cycles with `lock = 1`.
- Back-to-back grants: there is no IDLE gap between them. `ack` for the next source pulses on the cycle after the last hold cycle of the previous one.
- Return to IDLE: `disp` shows `OBUS` sampled at the exit edge, i.e. the first IDLE cycle shows the `OBUS` value one cycle old.
- `HOLD_CYC = 1`: each grant shows for one cycle, and consecutive grants appear on consecutive cycles.
- `cnt` never exceeds `HOLD_CYC-1`.

## Test plan
All scenarios use `HOLD_CYC = 4`.
- Reset mid-SHOW:
  - Stimulus: grant source 2, then assert `CLR` asynchronously at cycle 2 of hold.
  - Required: `disp = 0x00`, `gnt = 0`, `busy = 0`, `ack = 0` immediately. After release, `OBUS = 0x3C` appears on `disp` 1 cycle later, and no stale grant occurs.
- Single request with snapshot:
  - Stimulus: `d2 = 0xA5`, pulse `req[1]`; change `d2` to 0x00 one cycle after `ack`.
  - Required: `ack = 3'b010` for one cycle, `gnt = 2`, `disp = 0xA5` for exactly 4 cycles, then `gnt = 0` and `disp = OBUS`.
- Simultaneous requests from reset:
  - Stimulus: `req = 3'b111` in one cycle.
  - Required: grants to sources 1, 2, 3 in order, 4 cycles each, `busy` high 12 contiguous cycles, then IDLE.
- Round-robin pointer:
  - Stimulus: after serving source 2, raise `req[0]` and `req[2]` together.
  - Required: source 3 is granted first, then source 1.
- Lock:
  - Stimulus: assert `lock` for 10 cycles starting at hold cycle 1 of source 1.
  - Required: `gnt = 1` and `disp` stable for 14 cycles total, then IDLE. A request arriving during lock is served afterwards.
- Level request and re-queue:
  - Stimulus: hold `req[0]` high for 20 cycles.
  - Required: exactly one `ack[0]` pulse.
  - Stimulus: a new rise on `req[0]` during source 1's own SHOW.
  - Required: source 1 is re-granted back-to-back with one more `ack[0]` pulse.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the two-digit seven-segment display between the live
// output register (source 0) and three transient requesters (sources 1..3).
// A granted requester is shown as a frozen snapshot for HOLD_CYC cycles.
// Competing requests are served round-robin.
module disp_arbiter #(
    parameter int HOLD_CYC = 50_000_000,
    parameter int CW       = 26
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic [7:0] OBUS,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [2:0] req,
    input  logic       lock,
    output logic [7:0] disp,
    output logic [1:0] gnt,
    output logic [2:0] ack,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Last hold cycle. The counter runs 0..HOLD_CYC-1.
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

    // Registered state
    state_t        r_state;
    logic [2:0]    r_req_q;
    logic [2:0]    r_pending;
    logic [1:0]    r_ptr;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_disp;
    logic [1:0]    r_gnt;
    logic [2:0]    r_ack;

    // Next-state values and combinational helpers
    state_t        w_state_next;
    logic [2:0]    w_pending_next;
    logic [1:0]    w_ptr_next;
    logic [CW-1:0] w_cnt_next;
    logic [7:0]    w_disp_next;
    logic [1:0]    w_gnt_next;
    logic [2:0]    w_ack_next;

    logic [2:0]    w_rise;
    logic [1:0]    w_cand [3];
    logic [2:0]    w_cand_hit;
    logic          w_win_valid;
    logic [1:0]    w_winner;
    logic [2:0]    w_win_onehot;
    logic [7:0]    w_win_data;
    logic          w_grant;
    logic [2:0]    w_grant_onehot;

    // Source number reached k steps after p, wrapping within 1..3.
    function automatic logic [1:0] rr_step(input logic [1:0] p, input int k);
        int v;
        v = (int'(p) + 2 + k) % 3;
        return 2'(v + 1);
    endfunction

    // Only the rising edge of each request line is significant.
    assign w_rise = req & ~r_req_q;

    // Search order ptr+1, ptr+2, ptr+3; each slot checks its source's pending bit.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            assign w_cand[gi]     = rr_step(r_ptr, gi + 1);
            assign w_cand_hit[gi] = r_pending[w_cand[gi] - 2'd1];
        end
    endgenerate

    // Pick the first pending source in round-robin order and fetch its data.
    always_comb begin
        w_win_valid = |w_cand_hit;
        w_winner    = w_cand[2];
        if (w_cand_hit[0]) begin
            w_winner = w_cand[0];
        end else if (w_cand_hit[1]) begin
            w_winner = w_cand[1];
        end
        w_win_onehot = 3'b001 << (w_winner - 2'd1);
        case (w_winner)
            2'd1:    w_win_data = d1;
            2'd2:    w_win_data = d2;
            2'd3:    w_win_data = d3;
            default: w_win_data = OBUS;
        endcase
    end

    // Next-state and output logic: grant decisions, hold counting, view select.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_disp_next  = r_disp;
        w_gnt_next   = r_gnt;
        w_ack_next   = 3'b000;
        w_grant      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Live view with one register of delay.
                w_disp_next = OBUS;
                w_gnt_next  = 2'd0;
                w_cnt_next  = '0;
                if (w_win_valid && !lock) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // lock freezes the hold counter and therefore the view.
                if (!lock) begin
                    if (r_cnt == HOLD_LAST) begin
                        if (w_win_valid) begin
                            w_grant = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_gnt_next   = 2'd0;
                            w_disp_next  = OBUS;
                            w_cnt_next   = '0;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A grant snapshots the winner's data and restarts the hold.
        if (w_grant) begin
            w_gnt_next  = w_winner;
            w_disp_next = w_win_data;
            w_ack_next  = w_win_onehot;
            w_cnt_next  = '0;
            w_ptr_next  = w_winner;
        end

        // A rise arriving on the grant cycle of the same source re-queues it.
        w_grant_onehot = w_grant ? w_win_onehot : 3'b000;
        w_pending_next = (r_pending & ~w_grant_onehot) | w_rise;
    end

    // State register; CLR discards everything, including queued requests.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            r_state   <= ST_IDLE;
            r_req_q   <= 3'b000;
            r_pending <= 3'b000;
            r_ptr     <= 2'd3;
            r_cnt     <= '0;
            r_disp    <= 8'h00;
            r_gnt     <= 2'd0;
            r_ack     <= 3'b000;
        end else begin
            r_state   <= w_state_next;
            r_req_q   <= req;
            r_pending <= w_pending_next;
            r_ptr     <= w_ptr_next;
            r_cnt     <= w_cnt_next;
            r_disp    <= w_disp_next;
            r_gnt     <= w_gnt_next;
            r_ack     <= w_ack_next;
        end
    end

    assign disp = r_disp;
    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign busy = (r_state == ST_SHOW);

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter with HOLD_CYC = 4. Expected grants are queued as
// stimulus is driven; a negedge monitor pops one per ack pulse and checks
// grant, snapshot and hold length.
module tb_disp_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       CLR = 1'b1;
    logic [7:0] OBUS = 8'h00;
    logic [7:0] d1 = 8'h11;
    logic [7:0] d2 = 8'h22;
    logic [7:0] d3 = 8'h33;
    logic [2:0] req = 3'b000;
    logic       lock = 1'b0;
    logic [7:0] disp;
    logic [1:0] gnt;
    logic [2:0] ack;
    logic       busy;

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
        int         hold;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    logic       mon_active = 1'b0;
    logic [1:0] mon_src    = 2'd0;
    logic [7:0] mon_data   = 8'h00;
    int         mon_hold   = 0;
    int         mon_len    = 0;
    int         ack0_cnt   = 0;

    disp_arbiter #(.HOLD_CYC(HOLD), .CW(26)) dut (
        .clk  (clk),
        .CLR  (CLR),
        .OBUS (OBUS),
        .d1   (d1),
        .d2   (d2),
        .d3   (d3),
        .req  (req),
        .lock (lock),
        .disp (disp),
        .gnt  (gnt),
        .ack  (ack),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] src, input logic [7:0] data, input int hold);
        exp_t e;
        e.src  = src;
        e.data = data;
        e.hold = hold;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input logic [2:0] mask, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ((ack & mask) != 3'b000) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int run;
        bit ok;
        run = 0;
        ok  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!busy && ack == 3'b000) run++;
            else run = 0;
            if (run >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
        check({tag, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] exp_ack;
        if (CLR) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                if (ack == 3'b000 && busy && gnt == mon_src) begin
                    mon_len++;
                    check("snapshot_stable", disp, mon_data);
                end else begin
                    check("hold_len", mon_len, mon_hold);
                    mon_active = 1'b0;
                end
            end
            if (ack != 3'b000) begin
                if (ack[0]) ack0_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", ack, 32'd0);
                end else begin
                    e       = exp_q.pop_front();
                    exp_ack = 3'b001 << (e.src - 2'd1);
                    check("ack_onehot", ack, exp_ack);
                    check("gnt", gnt, e.src);
                    check("disp_at_grant", disp, e.data);
                    check("busy_at_grant", busy, 1'b1);
                    mon_active = 1'b1;
                    mon_src    = e.src;
                    mon_data   = e.data;
                    mon_hold   = e.hold;
                    mon_len    = 1;
                end
            end
        end
    end

    initial begin
        int busy_run;
        int base;

        // Reset state
        #13;
        check("rst_disp", disp, 8'h00);
        check("rst_gnt", gnt, 2'd0);
        check("rst_ack", ack, 3'b000);
        check("rst_busy", busy, 1'b0);
        tick();
        CLR  = 1'b0;
        OBUS = 8'h5A;
        tick();
        tick();
        check("idle_live_obus", disp, 8'h5A);

        // Reset mid-SHOW
        push_exp(2'd2, d2, HOLD);
        req = 3'b010;
        tick();
        req = 3'b000;
        wait_ack(3'b010, "rstshow");
        tick();
        #2;
        CLR = 1'b1;
        #1;
        check("clr_disp", disp, 8'h00);
        check("clr_gnt", gnt, 2'd0);
        check("clr_busy", busy, 1'b0);
        check("clr_ack", ack, 3'b000);
        OBUS = 8'h3C;
        tick();
        tick();
        CLR = 1'b0;
        tick();
        check("post_clr_obus", disp, 8'h3C);
        check("post_clr_busy", busy, 1'b0);
        wait_idle("rstshow");
        check("no_stale_gnt", gnt, 2'd0);

        // Single request with snapshot
        d2 = 8'hA5;
        push_exp(2'd2, 8'hA5, HOLD);
        req = 3'b010;
        tick();
        req = 3'b000;
        wait_ack(3'b010, "snap");
        tick();
        d2 = 8'h00;
        wait_idle("snap");
        check("snap_gnt_idle", gnt, 2'd0);
        check("snap_disp_obus", disp, OBUS);
        d2 = 8'h22;

        // Round-robin after source 2: 3 first, then 1
        push_exp(2'd3, d3, HOLD);
        push_exp(2'd1, d1, HOLD);
        req = 3'b101;
        tick();
        req = 3'b000;
        wait_idle("rr");

        // Simultaneous requests from reset
        #2;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        push_exp(2'd1, d1, HOLD);
        push_exp(2'd2, d2, HOLD);
        push_exp(2'd3, d3, HOLD);
        req = 3'b111;
        tick();
        req = 3'b000;
        busy_run = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy) busy_run++;
            else if (busy_run > 0) break;
        end
        check("busy_contiguous", busy_run, 3 * HOLD);
        wait_idle("simul");

        // Lock during source 1, request for source 2 arriving under lock
        push_exp(2'd1, d1, HOLD + 10);
        push_exp(2'd2, d2, HOLD);
        req = 3'b001;
        tick();
        req = 3'b000;
        wait_ack(3'b001, "lock");
        tick();
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) req = 3'b010;
            if (i == 4) req = 3'b000;
        end
        lock = 1'b0;
        wait_idle("lock");

        // Level request: one grant only
        base = ack0_cnt;
        push_exp(2'd1, d1, HOLD);
        req = 3'b001;
        repeat (20) tick();
        req = 3'b000;
        wait_idle("level");
        check("level_one_ack", ack0_cnt - base, 32'd1);

        // New rise during own SHOW re-grants back-to-back
        base = ack0_cnt;
        push_exp(2'd1, d1, HOLD);
        push_exp(2'd1, d1, HOLD);
        req = 3'b001;
        tick();
        req = 3'b000;
        wait_ack(3'b001, "requeue");
        tick();
        req = 3'b001;
        tick();
        req = 3'b000;
        wait_idle("requeue");
        check("requeue_two_acks", ack0_cnt - base, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
